// File: rtl/pmbist_mem_sequencer.sv
// SRAM access sequencer: arbitrates between the functional port and the pmbist engine and
// checks engine reads in a latency-matched pipe. Define PMBIST_FAIL_LOG_EN for first-fail capture.
module pmbist_mem_sequencer #(
  parameter int AX_WIDTH       = 2,
  parameter int AY_WIDTH       = 2,
  parameter int D_WIDTH        = 2,
  parameter int RD_LATENCY     = 1,
  parameter int FAIL_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_mbist_run,
  input  logic [1:0]                   i_op_cmd,
  input  logic [AX_WIDTH-1:0]          i_addr_x,
  input  logic [AY_WIDTH-1:0]          i_addr_y,
  input  logic [D_WIDTH-1:0]           i_data,
  input  logic                         i_end_of_prog,
  input  logic                         i_func_req,
  input  logic                         i_func_we,
  input  logic [AX_WIDTH+AY_WIDTH-1:0] i_func_addr,
  input  logic [D_WIDTH-1:0]           i_func_wdata,
  output logic                         o_func_gnt,
  output logic [D_WIDTH-1:0]           o_func_rdata,
  output logic                         o_func_rvalid,
  output logic                         o_mem_we,
  output logic                         o_mem_re,
  output logic                         o_mem_oe,
  output logic [AX_WIDTH+AY_WIDTH-1:0] o_mem_a,
  output logic [D_WIDTH-1:0]           o_mem_d,
  input  logic [D_WIDTH-1:0]           i_mem_q,
  output logic                         o_bist_busy,
  output logic                         o_bist_done,
  output logic                         o_bist_fail,
  output logic [FAIL_CNT_WIDTH-1:0]    o_fail_cnt
`ifdef PMBIST_FAIL_LOG_EN
  ,
  output logic [AX_WIDTH+AY_WIDTH-1:0] o_fail_addr,
  output logic [D_WIDTH-1:0]           o_fail_q
`endif
);

  localparam int A_WIDTH = AX_WIDTH + AY_WIDTH;
  localparam int L       = RD_LATENCY;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_BIST, S_FLUSH, S_DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                abort_q;
  logic                gnt;
  logic                issue;
  logic                drain_entry;
  logic                pending;
  logic                rd_launch;
  logic                miscmp;
  logic [A_WIDTH-1:0]  eng_addr;

  // read pipe: stage 0 is loaded together with the SRAM strobe, stage L lines up with i_mem_q
  logic [L:0]          vld_p;
  logic [L:0]          bist_p;
  logic [D_WIDTH-1:0]  exp_p [0:L];

  function automatic logic [FAIL_CNT_WIDTH-1:0] sat_inc(input logic [FAIL_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + FAIL_CNT_WIDTH'(1);
  endfunction

  assign eng_addr  = {i_addr_x, i_addr_y};
  // the entry in stage L completes this cycle, so only earlier stages hold up a handover
  assign pending   = |vld_p[L-1:0];
  assign rd_launch = (gnt & ~i_func_we) | (issue & (i_op_cmd == OP_READ));
  assign miscmp    = vld_p[L] & bist_p[L] & (i_mem_q != exp_p[L]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_mbist_run) state_nxt = S_DRAIN;
      S_DRAIN: if (!pending) state_nxt = S_BIST;
      S_BIST:  if (i_end_of_prog || !i_mbist_run) state_nxt = S_FLUSH;
      S_FLUSH: if (!pending) state_nxt = abort_q ? S_IDLE : S_DONE;
      S_DONE:  if (!i_mbist_run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt         = 1'b0;
    issue       = 1'b0;
    drain_entry = 1'b0;
    o_bist_busy = 1'b0;
    o_bist_done = 1'b0;
    case (state)
      S_IDLE: begin
        gnt         = i_func_req & ~i_mbist_run;
        drain_entry = i_mbist_run;
      end
      S_DRAIN: o_bist_busy = 1'b1;
      S_BIST: begin
        o_bist_busy = 1'b1;
        issue       = i_mbist_run;
      end
      S_FLUSH: o_bist_busy = 1'b1;
      S_DONE:  o_bist_done = 1'b1;
      default: ;
    endcase
  end

  assign o_func_gnt    = gnt;
  assign o_func_rvalid = vld_p[L] & ~bist_p[L];
  assign o_func_rdata  = o_func_rvalid ? i_mem_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else if (drain_entry) begin
      abort_q <= 1'b0;
    end else if (state == S_BIST && state_nxt == S_FLUSH) begin
      abort_q <= ~i_mbist_run;
    end
  end

  // ---- stage p0: registered SRAM strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      o_mem_oe <= 1'b0;
      o_mem_a  <= '0;
      o_mem_d  <= '0;
    end else begin
      o_mem_oe <= 1'b1;
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      if (gnt) begin
        o_mem_we <= i_func_we;
        o_mem_re <= ~i_func_we;
        o_mem_a  <= i_func_addr;
        o_mem_d  <= i_func_wdata;
      end else if (issue) begin
        o_mem_we <= (i_op_cmd == OP_WRITE);
        o_mem_re <= (i_op_cmd == OP_READ);
        if (i_op_cmd == OP_WRITE || i_op_cmd == OP_READ) o_mem_a <= eng_addr;
        if (i_op_cmd == OP_WRITE) o_mem_d <= i_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p  <= '0;
      bist_p <= '0;
    end else begin
      vld_p  <= {vld_p[L-1:0], rd_launch};
      bist_p <= {bist_p[L-1:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0] <= i_data;
    for (int k = 1; k <= L; k++) exp_p[k] <= exp_p[k-1];
  end

  // ---- stage pL: compare against returning read data ----
  always_ff @(posedge clk) begin
    if (rst || drain_entry) begin
      o_bist_fail <= 1'b0;
      o_fail_cnt  <= '0;
    end else if (miscmp) begin
      o_bist_fail <= 1'b1;
      o_fail_cnt  <= sat_inc(o_fail_cnt);
    end
  end

`ifdef PMBIST_FAIL_LOG_EN
  logic [A_WIDTH-1:0] addr_p [0:L];

  always_ff @(posedge clk) begin
    addr_p[0] <= eng_addr;
    for (int k = 1; k <= L; k++) addr_p[k] <= addr_p[k-1];
  end

  // o_bist_fail still low means this is the first miscompare of the run
  always_ff @(posedge clk) begin
    if (rst || drain_entry) begin
      o_fail_addr <= '0;
      o_fail_q    <= '0;
    end else if (miscmp && !o_bist_fail) begin
      o_fail_addr <= addr_p[L];
      o_fail_q    <= i_mem_q;
    end
  end
`endif

endmodule

// File: doc/pmbist_mem_sequencer.md
# pmbist_mem_sequencer

Owns the single-port SRAM access path between the functional requester and the pmbist microcode engine. It hands the memory over to the engine while `i_mbist_run` is high and turns each engine `op_cmd`/address/data beat into registered SRAM strobes. It also compares read data against the engine's expected data through a latency-matched pipeline and reports pass/fail status. It sits between `microcode_container` and the SRAM macro.

## Interface
- `AX_WIDTH`, default 2, row (X) address width
- `AY_WIDTH`, default 2, column (Y) address width; `A_WIDTH = AX_WIDTH+AY_WIDTH` (derived)
- `D_WIDTH`, default 2, data width
- `RD_LATENCY`, default 1, SRAM read latency in cycles, legal 1..3
- `FAIL_CNT_WIDTH`, default 8, fail counter width

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_mbist_run`  in  1  engine requests ownership / run
- `i_op_cmd`  in  2  engine op: NOP=2'b00, WRITE=2'b01, READ=2'b10; 2'b11 treated as NOP
- `i_addr_x`  in  AX_WIDTH  engine X address
- `i_addr_y`  in  AY_WIDTH  engine Y address
- `i_data`  in  D_WIDTH  write data (WRITE) or expected data (READ)
- `i_end_of_prog`  in  1  engine program finished (pulse)
- `i_func_req`, `i_func_we`  in  1  functional request / write-not-read
- `i_func_addr`  in  A_WIDTH  functional address
- `i_func_wdata`  in  D_WIDTH  functional write data
- `o_func_gnt`  out  1  functional request accepted this cycle
- `o_func_rdata`  out  D_WIDTH  functional read data; `o_func_rvalid` out 1 qualifies it
- `o_mem_we`, `o_mem_re`, `o_mem_oe`  out  1  SRAM strobes
- `o_mem_a`  out  A_WIDTH  SRAM address; `o_mem_d` out D_WIDTH SRAM write data
- `i_mem_q`  in  D_WIDTH  SRAM read data
- `o_bist_busy`, `o_bist_done`, `o_bist_fail`  out  1  status
- `o_fail_cnt`  out  FAIL_CNT_WIDTH  saturating miscompare count

## Operation
- FSM: IDLE, DRAIN, BIST, FLUSH, DONE.
- IDLE: functional path owns memory.
  - `o_func_gnt = i_func_req & (state==IDLE) & ~i_mbist_run` (combinational).
  - `i_mbist_run`=1 → DRAIN.
  - Entering DRAIN clears `o_bist_fail`, `o_fail_cnt`, fail log.
- DRAIN: no new grants. Stay until the read pipe is empty (≤RD_LATENCY cycles), then → BIST.
- BIST: engine owns memory. Each cycle the engine beat is registered to SRAM:
  - WRITE: we=1, re=0, `o_mem_d=i_data`.
  - READ: re=1, we=0; `i_data` pushed as expected into the compare pipe.
  - NOP: both 0.
  - Exits: `i_end_of_prog`=1 → FLUSH; `i_mbist_run`=0 (abort) → FLUSH with abort flag set.
- FLUSH: no new strobes. Wait RD_LATENCY cycles for final compares. Normal exit → DONE; abort exit → IDLE with done never set.
- DONE: `o_bist_done`=1 held until `i_mbist_run`=0, then → IDLE.
- Address: `o_mem_a = {addr_x, addr_y}`; X is the MSBs.
- Compare: a valid pipe entry with `i_mem_q != expected` → `o_bist_fail`=1 (sticky) and `o_fail_cnt`+1, saturating at all-ones.
- `o_mem_oe`=1 in every state except during reset.
- `o_bist_busy`=1 in DRAIN, BIST, FLUSH.

## Timing
- Reset value of every output is 0, FSM → IDLE, pipes emptied. Reset mid-BIST aborts with no done.
- Strobe latency: command in cycle N appears on `o_mem_*` in cycle N+1.
- Read data is sampled at N+1+RD_LATENCY; compare and `o_fail_cnt` update are visible at N+2+RD_LATENCY.
- Functional read: `o_func_rvalid` pulses with data at N+1+RD_LATENCY after grant in cycle N. One grant per cycle, back-to-back allowed.
- Same-cycle `i_mbist_run` rise and `i_func_req`: BIST wins, no grant.
- Same-cycle `i_end_of_prog` and an op: the op is issued, then FLUSH.
- Ops arriving in FLUSH, DONE, or IDLE from the engine are ignored.

## Configuration
- `PMBIST_FAIL_LOG_EN` defined: adds `o_fail_addr` (A_WIDTH) and `o_fail_q` (D_WIDTH). They capture the address and read data of the first miscompare after run start and hold until the next DRAIN entry.
- Undefined: those ports and registers are absent; only `o_bist_fail`/`o_fail_cnt` are reported.

## Test plan
- Reset: assert `rst` mid-BIST with 3 reads in flight → next cycle all outputs 0, state IDLE; a later run starts with fail_cnt=0.
- Clean March pass: AX=AY=2, D=2, engine writes 0 to all 16 cells, then reads 0 → `o_bist_done`=1, `o_bist_fail`=0, `o_fail_cnt`=0; `o_mem_a` sequence 0..15.
- Stuck bit: model cell {ax=2,ay=1} (address 9) as bit0 stuck-at-1, run 0/1 March → fail=1, fail_cnt equals the number of reads of cell 9 expecting bit0=0. With `PMBIST_FAIL_LOG_EN`: fail_addr=9, fail_q=2'b01.
- Handover: functional reads of address 5 in the cycle before `i_mbist_run` rises, RD_LATENCY=3 → rvalid delivered; first engine strobe is no earlier than 3 cycles later; `o_func_gnt`=0 throughout BIST.
- Saturation: FAIL_CNT_WIDTH=2, inject 6 miscompares → `o_fail_cnt`=3.
- Abort: drop `i_mbist_run` mid-BIST → FLUSH then IDLE, `o_bist_done` never 1, fail status retained.
